// File: rtl/systolic_feeder_2x2.sv
// Operand feeder and result capture for a 2x2 output-stationary systolic array.
// Streams A columns / B rows over two cycles, then captures the array accumulators.
module systolic_feeder_2x2 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a00,
  input  logic [W-1:0]   a01,
  input  logic [W-1:0]   a10,
  input  logic [W-1:0]   a11,
  input  logic [W-1:0]   b00,
  input  logic [W-1:0]   b01,
  input  logic [W-1:0]   b10,
  input  logic [W-1:0]   b11,
  input  logic [2*W:0]   o1,
  input  logic [2*W:0]   o2,
  input  logic [2*W:0]   o3,
  input  logic [2*W:0]   o4,
  output logic [W-1:0]   a0,
  output logic [W-1:0]   a1,
  output logic [W-1:0]   b0,
  output logic [W-1:0]   b1,
  output logic           arr_rst_n,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   c00,
  output logic [2*W:0]   c01,
  output logic [2*W:0]   c10,
  output logic [2*W:0]   c11
);

  typedef enum logic [2:0] {IDLE, CLR, K0, K1, FLUSH, DONE} state_t;

  state_t state, state_nx;

  logic [W-1:0] ra00, ra01, ra10, ra11;
  logic [W-1:0] rb00, rb01, rb10, rb11;

  logic [W-1:0] a0_nx, a1_nx, b0_nx, b1_nx;
  logic         arr_rst_n_nx, busy_nx, done_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs are decoded from the state being entered so every port is a plain flop.
  always_comb begin
    state_nx     = state;
    a0_nx        = '0;
    a1_nx        = '0;
    b0_nx        = '0;
    b1_nx        = '0;
    arr_rst_n_nx = 1'b1;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;

    case (state)
      IDLE:    if (start) state_nx = CLR;
      CLR:     state_nx = K0;
      K0:      state_nx = K1;
      K1:      state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      CLR: begin
        arr_rst_n_nx = 1'b0;
        busy_nx      = 1'b1;
      end
      K0: begin
        a0_nx   = ra00;
        a1_nx   = ra10;
        b0_nx   = rb00;
        b1_nx   = rb01;
        busy_nx = 1'b1;
      end
      K1: begin
        a0_nx   = ra01;
        a1_nx   = ra11;
        b0_nx   = rb10;
        b1_nx   = rb11;
        busy_nx = 1'b1;
      end
      FLUSH:   busy_nx = 1'b1;
      DONE:    done_nx = 1'b1;
      default: ;
    endcase
  end

  // Operands are only sampled on an accepted start, isolating the run from later input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra00 <= '0;
      ra01 <= '0;
      ra10 <= '0;
      ra11 <= '0;
      rb00 <= '0;
      rb01 <= '0;
      rb10 <= '0;
      rb11 <= '0;
    end else if (state == IDLE && start) begin
      ra00 <= a00;
      ra01 <= a01;
      ra10 <= a10;
      ra11 <= a11;
      rb00 <= b00;
      rb01 <= b01;
      rb10 <= b10;
      rb11 <= b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
      arr_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      a0        <= a0_nx;
      a1        <= a1_nx;
      b0        <= b0_nx;
      b1        <= b1_nx;
      arr_rst_n <= arr_rst_n_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // The last accumulating edge is the end of K1, so the array sums are settled throughout FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c00 <= '0;
      c01 <= '0;
      c10 <= '0;
      c11 <= '0;
    end else if (state == FLUSH) begin
      c00 <= o1;
      c01 <= o2;
      c10 <= o3;
      c11 <= o4;
    end
  end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Self-checking bench for systolic_feeder_2x2: behavioural 2x2 array, schedule-based
// reference model, per-cycle compare, directed literal cases and a randomized phase.
module tb_systolic_feeder_2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a00 = '0, a01 = '0, a10 = '0, a11 = '0;
  logic [7:0]  b00 = '0, b01 = '0, b10 = '0, b11 = '0;
  logic [16:0] o1, o2, o3, o4;
  logic [7:0]  a0, a1, b0, b1;
  logic        arr_rst_n, busy, done;
  logic [16:0] c00, c01, c10, c11;

  systolic_feeder_2x2 #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .arr_rst_n(arr_rst_n), .busy(busy), .done(done),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11)
  );

  always #5 clk = ~clk;

  // Downstream output-stationary array: PE(i,j) accumulates stream a_i times stream b_j.
  logic [16:0] acc [4];
  always @(posedge clk) begin
    if (!arr_rst_n) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      acc[0] <= acc[0] + a0 * b0;
      acc[1] <= acc[1] + a0 * b1;
      acc[2] <= acc[2] + a1 * b0;
      acc[3] <= acc[3] + a1 * b1;
    end
  end
  assign o1 = acc[0];
  assign o2 = acc[1];
  assign o3 = acc[2];
  assign o4 = acc[3];

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start schedules a fixed six-cycle timeline of output values.
  logic [7:0]  expA0 = '0, expA1 = '0, expB0 = '0, expB1 = '0;
  logic        expArr = 1'b0, expBusy = 1'b0, expDone = 1'b0;
  logic [16:0] expC [4] = '{default: '0};
  int          mA [4];
  int          mB [4];
  bit          running = 0;
  int          k = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      running = 0;
      expA0 = '0; expA1 = '0; expB0 = '0; expB1 = '0;
      expArr = 1'b0; expBusy = 1'b0; expDone = 1'b0;
      for (int i = 0; i < 4; i++) expC[i] = '0;
    end else begin
      if (running) begin
        k++;
        if (k == 6) running = 0;
      end
      if (!running && start) begin
        running = 1;
        k = 0;
        mA = '{int'(a00), int'(a01), int'(a10), int'(a11)};
        mB = '{int'(b00), int'(b01), int'(b10), int'(b11)};
      end
      expA0 = '0; expA1 = '0; expB0 = '0; expB1 = '0;
      expArr = 1'b1; expBusy = 1'b0; expDone = 1'b0;
      if (running) begin
        if (k <= 3) expBusy = 1'b1;
        if (k == 0) expArr = 1'b0;
        if (k == 1) begin
          expA0 = 8'(mA[0]); expA1 = 8'(mA[2]); expB0 = 8'(mB[0]); expB1 = 8'(mB[1]);
        end
        if (k == 2) begin
          expA0 = 8'(mA[1]); expA1 = 8'(mA[3]); expB0 = 8'(mB[2]); expB1 = 8'(mB[3]);
        end
        if (k == 4) begin
          expDone = 1'b1;
          expC[0] = 17'(mA[0] * mB[0] + mA[1] * mB[2]);
          expC[1] = 17'(mA[0] * mB[1] + mA[1] * mB[3]);
          expC[2] = 17'(mA[2] * mB[0] + mA[3] * mB[2]);
          expC[3] = 17'(mA[2] * mB[1] + mA[3] * mB[3]);
        end
      end
    end
  end

  typedef struct packed {
    int          idx;
    logic [16:0] r00, r01, r10, r11;
  } done_t;

  done_t doneQ [$];
  int    negCnt = 0;
  int    busyCnt = 0;

  always @(negedge clk) begin
    done_t d;
    negCnt++;
    checkOutput("a0", a0, expA0);
    checkOutput("a1", a1, expA1);
    checkOutput("b0", b0, expB0);
    checkOutput("b1", b1, expB1);
    checkOutput("arr_rst_n", arr_rst_n, expArr);
    checkOutput("busy", busy, expBusy);
    checkOutput("done", done, expDone);
    checkOutput("c00", c00, expC[0]);
    checkOutput("c01", c01, expC[1]);
    checkOutput("c10", c10, expC[2]);
    checkOutput("c11", c11, expC[3]);
    if (busy) busyCnt++;
    if (done) begin
      d.idx = negCnt;
      d.r00 = c00; d.r01 = c01; d.r10 = c10; d.r11 = c11;
      doneQ.push_back(d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st,
                               input logic [7:0] m00, m01, m10, m11,
                               input logic [7:0] n00, n01, n10, n11);
    start = st;
    a00 = m00; a01 = m01; a10 = m10; a11 = m11;
    b00 = n00; b01 = n01; b10 = n10; b11 = n11;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic checkResult(input string name, input done_t d,
                             input int e00, e01, e10, e11);
    checkOutput({name, ".c00"}, d.r00, e00);
    checkOutput({name, ".c01"}, d.r01, e01);
    checkOutput({name, ".c10"}, d.r10, e10);
    checkOutput({name, ".c11"}, d.r11, e11);
  endtask

  initial begin
    int s;
    done_t none;
    none = '0;

    waitCycles(3);
    rst = 1'b0;
    step();
    checkOutput("post_reset_arr_rst_n", arr_rst_n, 1);

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    doneQ.delete();
    busyCnt = 0;
    applyStimulus(1, 1, 2, 3, 4, 5, 6, 7, 8);
    step();
    s = negCnt;
    start = 1'b0;
    waitCycles(8);
    checkOutput("basic_done_count", doneQ.size(), 1);
    checkOutput("basic_busy_cycles", busyCnt, 4);
    if (doneQ.size() > 0) begin
      checkOutput("basic_done_latency", doneQ[0].idx - s, 5);
      checkResult("basic", doneQ[0], 19, 22, 43, 50);
    end else checkResult("basic", none, 19, 22, 43, 50);

    // all-ones operands at full scale
    doneQ.delete();
    applyStimulus(1, 255, 255, 255, 255, 255, 255, 255, 255);
    step();
    start = 1'b0;
    waitCycles(8);
    checkOutput("max_done_count", doneQ.size(), 1);
    checkResult("max", (doneQ.size() > 0) ? doneQ[0] : none, 130050, 130050, 130050, 130050);

    // start held high across two runs; B changes while the first run is busy
    doneQ.delete();
    applyStimulus(1, 1, 0, 0, 1, 9, 8, 7, 6);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 2) applyStimulus(1, 1, 0, 0, 1, 1, 1, 1, 1);
    end
    start = 1'b0;
    waitCycles(10);
    checkOutput("b2b_done_count", doneQ.size(), 2);
    if (doneQ.size() >= 2) begin
      checkOutput("b2b_done_spacing", doneQ[1].idx - doneQ[0].idx, 6);
      checkResult("b2b_first", doneQ[0], 9, 8, 7, 6);
      checkResult("b2b_second", doneQ[1], 1, 1, 1, 1);
    end else checkResult("b2b_first", none, 9, 8, 7, 6);

    // start pulsed in K1 and in DONE must be ignored
    doneQ.delete();
    applyStimulus(1, 1, 2, 3, 4, 1, 0, 0, 1);
    step();
    applyStimulus(0, 1, 2, 3, 4, 1, 0, 0, 1);
    step();
    step();
    applyStimulus(1, 9, 9, 9, 9, 9, 9, 9, 9);
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    waitCycles(8);
    checkOutput("ignore_done_count", doneQ.size(), 1);
    checkResult("ignore", (doneQ.size() > 0) ? doneQ[0] : none, 1, 2, 3, 4);

    // reset during K0 aborts the run and clears results
    doneQ.delete();
    applyStimulus(1, 7, 7, 7, 7, 7, 7, 7, 7);
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checkOutput("abort_c00", c00, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_arr_rst_n", arr_rst_n, 0);
    step();
    rst = 1'b0;
    waitCycles(8);
    checkOutput("abort_done_count", doneQ.size(), 0);
    applyStimulus(1, 2, 0, 0, 2, 3, 4, 5, 6);
    step();
    start = 1'b0;
    waitCycles(8);
    checkOutput("after_abort_done_count", doneQ.size(), 1);
    checkResult("after_abort", (doneQ.size() > 0) ? doneQ[0] : none, 6, 8, 10, 12);

    // randomized starts, operands and occasional resets, checked per cycle by the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus(1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    waitCycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
